// File: rtl/saph_vidgen_pkg.sv
// Shared definitions for the video-generator control block: FSM states,
// staging register map and the 640x480 power-up timing.
package saph_vidgen_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RUN,
        ST_PEND,
        ST_DRAIN,
        ST_LOAD
    } state_t;

    localparam logic [3:0] ADDR_CLK_DIV = 4'd0;
    localparam logic [3:0] ADDR_H_FP    = 4'd1;
    localparam logic [3:0] ADDR_H_VID   = 4'd2;
    localparam logic [3:0] ADDR_H_BP    = 4'd3;
    localparam logic [3:0] ADDR_H_SYNC  = 4'd4;
    localparam logic [3:0] ADDR_V_FP    = 4'd5;
    localparam logic [3:0] ADDR_V_VID   = 4'd6;
    localparam logic [3:0] ADDR_V_BP    = 4'd7;
    localparam logic [3:0] ADDR_V_SYNC  = 4'd8;

    localparam int unsigned DEF_CLK_DIV = 0;
    localparam int unsigned DEF_H_FP    = 15;
    localparam int unsigned DEF_H_VID   = 639;
    localparam int unsigned DEF_H_BP    = 47;
    localparam int unsigned DEF_H_SYNC  = 95;
    localparam int unsigned DEF_V_FP    = 9;
    localparam int unsigned DEF_V_VID   = 479;
    localparam int unsigned DEF_V_BP    = 32;
    localparam int unsigned DEF_V_SYNC  = 1;

endpackage

// File: rtl/saph_vidgen_ctrl_regfile.sv
// Staging register file for the video timing fields, with combinational
// zero-extended readback of the addressed field.
module saph_vidgen_ctrl_regfile
    import saph_vidgen_pkg::*;
#(
    parameter int unsigned div_width = 6,
    parameter int unsigned x_width   = 10,
    parameter int unsigned y_width   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [3:0]           addr,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata,
    output logic [div_width-1:0] clk_div,
    output logic [x_width-1:0]   h_fp,
    output logic [x_width-1:0]   h_vid,
    output logic [x_width-1:0]   h_bp,
    output logic [x_width-1:0]   h_sync,
    output logic [y_width-1:0]   v_fp,
    output logic [y_width-1:0]   v_vid,
    output logic [y_width-1:0]   v_bp,
    output logic [y_width-1:0]   v_sync
);

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_div <= div_width'(DEF_CLK_DIV);
            h_fp    <= x_width'(DEF_H_FP);
            h_vid   <= x_width'(DEF_H_VID);
            h_bp    <= x_width'(DEF_H_BP);
            h_sync  <= x_width'(DEF_H_SYNC);
            v_fp    <= y_width'(DEF_V_FP);
            v_vid   <= y_width'(DEF_V_VID);
            v_bp    <= y_width'(DEF_V_BP);
            v_sync  <= y_width'(DEF_V_SYNC);
        end else if (we) begin
            // Addresses 9..15 fall through to default and are dropped.
            case (addr)
                ADDR_CLK_DIV: clk_div <= wdata[div_width-1:0];
                ADDR_H_FP:    h_fp    <= wdata[x_width-1:0];
                ADDR_H_VID:   h_vid   <= wdata[x_width-1:0];
                ADDR_H_BP:    h_bp    <= wdata[x_width-1:0];
                ADDR_H_SYNC:  h_sync  <= wdata[x_width-1:0];
                ADDR_V_FP:    v_fp    <= wdata[y_width-1:0];
                ADDR_V_VID:   v_vid   <= wdata[y_width-1:0];
                ADDR_V_BP:    v_bp    <= wdata[y_width-1:0];
                ADDR_V_SYNC:  v_sync  <= wdata[y_width-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CLK_DIV: rdata = 16'(clk_div);
            ADDR_H_FP:    rdata = 16'(h_fp);
            ADDR_H_VID:   rdata = 16'(h_vid);
            ADDR_H_BP:    rdata = 16'(h_bp);
            ADDR_H_SYNC:  rdata = 16'(h_sync);
            ADDR_V_FP:    rdata = 16'(v_fp);
            ADDR_V_VID:   rdata = 16'(v_vid);
            ADDR_V_BP:    rdata = 16'(v_bp);
            ADDR_V_SYNC:  rdata = 16'(v_sync);
            default:      rdata = '0;
        endcase
    end

endmodule

// File: rtl/saph_vidgen_ctrl.sv
// Video-generator control: commits staged timing to the active registers at a
// vsync boundary after draining the generator. Optional PEND watchdog: SAPH_VIDGEN_CTRL_TIMEOUT_EN.
module saph_vidgen_ctrl
    import saph_vidgen_pkg::*;
#(
    parameter int unsigned div_width     = 6,
    parameter int unsigned x_width       = 10,
    parameter int unsigned y_width       = 10,
    parameter int unsigned drain_cycles  = 4,
    parameter int unsigned timeout_width = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_we,
    input  logic [3:0]           reg_addr,
    input  logic [15:0]          reg_wdata,
    output logic [15:0]          reg_rdata,
    input  logic                 run,
    input  logic                 apply,
    input  logic                 vsync,
    output logic                 en,
    output logic [div_width-1:0] vga_clk_div,
    output logic [x_width-1:0]   h_fp_width,
    output logic [x_width-1:0]   h_vid_width,
    output logic [x_width-1:0]   h_bp_width,
    output logic [x_width-1:0]   h_sync_width,
    output logic [y_width-1:0]   v_fp_width,
    output logic [y_width-1:0]   v_vid_width,
    output logic [y_width-1:0]   v_bp_width,
    output logic [y_width-1:0]   v_sync_width,
    output logic                 busy,
    output logic                 applied,
    output logic                 timeout
);

    localparam logic [7:0] DRAIN_LAST = 8'(drain_cycles - 1);

    logic [div_width-1:0] stg_clk_div;
    logic [x_width-1:0]   stg_h_fp, stg_h_vid, stg_h_bp, stg_h_sync;
    logic [y_width-1:0]   stg_v_fp, stg_v_vid, stg_v_bp, stg_v_sync;

    saph_vidgen_ctrl_regfile #(
        .div_width (div_width),
        .x_width   (x_width),
        .y_width   (y_width)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (reg_we),
        .addr    (reg_addr),
        .wdata   (reg_wdata),
        .rdata   (reg_rdata),
        .clk_div (stg_clk_div),
        .h_fp    (stg_h_fp),
        .h_vid   (stg_h_vid),
        .h_bp    (stg_h_bp),
        .h_sync  (stg_h_sync),
        .v_fp    (stg_v_fp),
        .v_vid   (stg_v_vid),
        .v_bp    (stg_v_bp),
        .v_sync  (stg_v_sync)
    );

    state_t     state, state_nx;
    logic       vsync_q;
    logic       vsync_rise;
    logic       commit, commit_nx;
    logic [7:0] drain_cnt, drain_cnt_nx;

    assign vsync_rise = vsync & ~vsync_q;

`ifdef SAPH_VIDGEN_CTRL_TIMEOUT_EN
    localparam logic [timeout_width-1:0] TMO_LAST = {{(timeout_width-1){1'b1}}, 1'b0};

    logic [timeout_width-1:0] tmo_cnt, tmo_cnt_nx;
    logic                     timeout_q, timeout_nx;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx     = state;
        commit_nx    = commit;
        drain_cnt_nx = '0;
`ifdef SAPH_VIDGEN_CTRL_TIMEOUT_EN
        tmo_cnt_nx   = '0;
        timeout_nx   = timeout_q;
`endif
        case (state)
            ST_OFF: begin
                if (apply) begin
                    state_nx = ST_LOAD;
`ifdef SAPH_VIDGEN_CTRL_TIMEOUT_EN
                    timeout_nx = 1'b0;
`endif
                end else if (run) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (apply) begin
                    state_nx = ST_PEND;
`ifdef SAPH_VIDGEN_CTRL_TIMEOUT_EN
                    timeout_nx = 1'b0;
`endif
                end else if (!run) begin
                    state_nx  = ST_DRAIN;
                    commit_nx = 1'b0;
                end
            end
            ST_PEND: begin
                if (vsync_rise) begin
                    state_nx  = ST_DRAIN;
                    commit_nx = 1'b1;
                end
`ifdef SAPH_VIDGEN_CTRL_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    state_nx   = ST_DRAIN;
                    commit_nx  = 1'b1;
                    timeout_nx = 1'b1;
                end else begin
                    tmo_cnt_nx = tmo_cnt + 1'b1;
                end
`endif
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nx = commit ? ST_LOAD : ST_OFF;
                end else begin
                    drain_cnt_nx = drain_cnt + 8'd1;
                end
            end
            ST_LOAD: begin
                state_nx  = run ? ST_RUN : ST_OFF;
                commit_nx = 1'b0;
            end
            default: state_nx = ST_OFF;
        endcase
    end

    assign en      = (state == ST_RUN) || (state == ST_PEND);
    assign busy    = (state == ST_PEND) || (state == ST_DRAIN) || (state == ST_LOAD);
    assign applied = (state == ST_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_OFF;
            vsync_q   <= 1'b0;
            commit    <= 1'b0;
            drain_cnt <= '0;
`ifdef SAPH_VIDGEN_CTRL_TIMEOUT_EN
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            vsync_q   <= vsync;
            commit    <= commit_nx;
            drain_cnt <= drain_cnt_nx;
`ifdef SAPH_VIDGEN_CTRL_TIMEOUT_EN
            tmo_cnt   <= tmo_cnt_nx;
            timeout_q <= timeout_nx;
`endif
        end
    end

    // Copy samples staging before this edge, so a write landing in the LOAD
    // cycle stays in staging for the next commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_clk_div  <= div_width'(DEF_CLK_DIV);
            h_fp_width   <= x_width'(DEF_H_FP);
            h_vid_width  <= x_width'(DEF_H_VID);
            h_bp_width   <= x_width'(DEF_H_BP);
            h_sync_width <= x_width'(DEF_H_SYNC);
            v_fp_width   <= y_width'(DEF_V_FP);
            v_vid_width  <= y_width'(DEF_V_VID);
            v_bp_width   <= y_width'(DEF_V_BP);
            v_sync_width <= y_width'(DEF_V_SYNC);
        end else if (state == ST_LOAD) begin
            vga_clk_div  <= stg_clk_div;
            h_fp_width   <= stg_h_fp;
            h_vid_width  <= stg_h_vid;
            h_bp_width   <= stg_h_bp;
            h_sync_width <= stg_h_sync;
            v_fp_width   <= stg_v_fp;
            v_vid_width  <= stg_v_vid;
            v_bp_width   <= stg_v_bp;
            v_sync_width <= stg_v_sync;
        end
    end

endmodule

// File: tb/tb_saph_vidgen_ctrl.sv
// Bench for saph_vidgen_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a behavioural model of the commit sequence.
module tb_saph_vidgen_ctrl;

    localparam int unsigned DIV_W = 6;
    localparam int unsigned X_W   = 10;
    localparam int unsigned Y_W   = 10;
    localparam int unsigned DRAIN = 4;
    localparam int unsigned TMO_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             reg_we = 1'b0;
    logic [3:0]       reg_addr = '0;
    logic [15:0]      reg_wdata = '0;
    logic [15:0]      reg_rdata;
    logic             run = 1'b0;
    logic             apply = 1'b0;
    logic             vsync = 1'b0;
    logic             en, busy, applied, timeout;
    logic [DIV_W-1:0] vga_clk_div;
    logic [X_W-1:0]   h_fp_width, h_vid_width, h_bp_width, h_sync_width;
    logic [Y_W-1:0]   v_fp_width, v_vid_width, v_bp_width, v_sync_width;

    saph_vidgen_ctrl #(
        .div_width     (DIV_W),
        .x_width       (X_W),
        .y_width       (Y_W),
        .drain_cycles  (DRAIN),
        .timeout_width (TMO_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_we       (reg_we),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .run          (run),
        .apply        (apply),
        .vsync        (vsync),
        .en           (en),
        .vga_clk_div  (vga_clk_div),
        .h_fp_width   (h_fp_width),
        .h_vid_width  (h_vid_width),
        .h_bp_width   (h_bp_width),
        .h_sync_width (h_sync_width),
        .v_fp_width   (v_fp_width),
        .v_vid_width  (v_vid_width),
        .v_bp_width   (v_bp_width),
        .v_sync_width (v_sync_width),
        .busy         (busy),
        .applied      (applied),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: register contents as plain arrays, controller
    // described by what the generator is doing (running, waiting, draining, loading).
    int unsigned defaults [9] = '{0, 15, 639, 47, 95, 9, 479, 32, 1};
    int unsigned stg [9];
    int unsigned act [9];
    bit          m_running, m_waiting, m_loading, m_commit, m_timeout, m_vs_prev;
    int unsigned m_drain_left, m_wait_cycles;
    bit          model_live = 1'b0;
`ifdef SAPH_VIDGEN_CTRL_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    function automatic int unsigned field_mask(input int unsigned idx);
        return (idx == 0) ? ((1 << DIV_W) - 1) : (idx <= 4) ? ((1 << X_W) - 1) : ((1 << Y_W) - 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) begin
            stg[i] = defaults[i];
            act[i] = defaults[i];
        end
        m_running = 0; m_waiting = 0; m_loading = 0; m_commit = 0;
        m_timeout = 0; m_vs_prev = 0; m_drain_left = 0; m_wait_cycles = 0;
    endtask

    task automatic model_step();
        bit vs_edge;
        bit was_loading;
        if (rst) begin
            model_reset();
            return;
        end
        vs_edge     = vsync && !m_vs_prev;
        was_loading = m_loading;
        if (was_loading)
            for (int i = 0; i < 9; i++) act[i] = stg[i];
        if (reg_we && reg_addr < 9)
            stg[reg_addr] = reg_wdata & field_mask(reg_addr);
        m_vs_prev = vsync;

        if (was_loading) begin
            m_loading = 0;
            m_running = run;
        end else if (m_drain_left > 0) begin
            m_drain_left--;
            if (m_drain_left == 0) begin
                m_loading = m_commit;
                m_commit  = 0;
            end
        end else if (m_waiting) begin
            m_wait_cycles++;
            if (vs_edge || (TMO_ON && m_wait_cycles == (1 << TMO_W) - 1)) begin
                if (!vs_edge) m_timeout = 1;
                m_waiting    = 0;
                m_commit     = 1;
                m_drain_left = DRAIN;
            end
        end else if (m_running) begin
            if (apply) begin
                m_running     = 0;
                m_waiting     = 1;
                m_wait_cycles = 0;
                m_timeout     = 0;
            end else if (!run) begin
                m_running    = 0;
                m_drain_left = DRAIN;
            end
        end else begin
            if (apply) begin
                m_loading = 1;
                m_timeout = 0;
            end else if (run) begin
                m_running = 1;
            end
        end
    endtask

    task automatic compare_outputs();
        int unsigned got [9];
        got = '{vga_clk_div, h_fp_width, h_vid_width, h_bp_width, h_sync_width,
                v_fp_width, v_vid_width, v_bp_width, v_sync_width};
        check_eq("en", en, m_running || m_waiting);
        check_eq("busy", busy, m_waiting || m_drain_left > 0 || m_loading);
        check_eq("applied", applied, m_loading);
        check_eq("timeout", timeout, m_timeout);
        for (int i = 0; i < 9; i++) check_eq($sformatf("active[%0d]", i), got[i], act[i]);
        check_eq("reg_rdata", reg_rdata, (reg_addr < 9) ? stg[reg_addr] : 0);
    endtask

    // Inputs are driven just after a falling edge; outputs are compared
    // 1 time unit later, then the model advances across the rising edge.
    task automatic tick();
        #1;
        if (model_live) compare_outputs();
        model_step();
        @(negedge clk);
        rst    = 1'b0;
        reg_we = 1'b0;
        apply  = 1'b0;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
    endtask

    int unsigned pulses;

    initial begin
        @(negedge clk);
        rst = 1'b1;
        tick();
        model_live = 1'b1;

        // Reset state and run start-up
        check_eq("rst_en", en, 1'b0);
        check_eq("rst_h_vid", h_vid_width, 639);
        check_eq("rst_busy", busy, 1'b0);
        run = 1'b1;
        tick();
        check_eq("run_en", en, 1'b1);

        // Commit in RUN waits for the vsync rise, then drains and loads
        write_reg(4'd2, 16'd799);
        apply = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check_eq("pend_en", en, 1'b1);
            tick();
        end
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        for (int i = 0; i < DRAIN; i++) begin
            check_eq("drain_en", en, 1'b0);
            tick();
        end
        check_eq("load_applied", applied, 1'b1);
        tick();
        check_eq("commit_h_vid", h_vid_width, 799);
        check_eq("rerun_en", en, 1'b1);

        // Stop: drain without commit
        run = 1'b0;
        tick();
        for (int i = 0; i < DRAIN; i++) begin
            check_eq("stop_applied", applied, 1'b0);
            tick();
        end
        check_eq("stop_busy", busy, 1'b0);
        check_eq("stop_h_vid", h_vid_width, 799);

        // Apply from OFF loads immediately
        write_reg(4'd6, 16'd599);
        apply = 1'b1;
        tick();
        check_eq("off_applied", applied, 1'b1);
        tick();
        check_eq("off_v_vid", v_vid_width, 599);
        check_eq("off_en", en, 1'b0);

        // Write landing in the LOAD cycle stays staged only
        apply = 1'b1;
        tick();
        write_reg(4'd1, 16'd20);
        check_eq("load_wr_h_fp", h_fp_width, 15);
        reg_addr = 4'd1;
        #1;
        check_eq("load_wr_rdata", reg_rdata, 20);

        // Apply while busy is ignored: exactly one applied pulse
        run = 1'b1;
        tick();
        write_reg(4'd3, 16'd50);
        apply = 1'b1;
        tick();
        apply = 1'b1;
        tick();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        pulses = 0;
        for (int i = 0; i < DRAIN + 3; i++) begin
            #1;
            pulses += applied;
            tick();
        end
        check_eq("busy_apply_pulses", pulses, 1);
        check_eq("busy_apply_h_bp", h_bp_width, 50);

`ifdef SAPH_VIDGEN_CTRL_TIMEOUT_EN
        // Watchdog forces the commit when vsync never rises
        write_reg(4'd4, 16'd77);
        apply = 1'b1;
        tick();
        for (int i = 0; i < (1 << TMO_W) - 2; i++) tick();
        check_eq("tmo_pre", timeout, 1'b0);
        tick();
        check_eq("tmo_set", timeout, 1'b1);
        for (int i = 0; i < DRAIN; i++) tick();
        check_eq("tmo_applied", applied, 1'b1);
        tick();
        check_eq("tmo_h_sync", h_sync_width, 77);
`endif

        // Reset mid-DRAIN aborts the commit
        write_reg(4'd2, 16'd123);
        apply = 1'b1;
        tick();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_en", en, 1'b0);
        check_eq("abort_h_vid", h_vid_width, 639);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(499) == 0);
            reg_we    = ($urandom_range(3) == 0);
            reg_addr  = 4'($urandom_range(15));
            reg_wdata = 16'($urandom);
            if ($urandom_range(39) == 0) run = ~run;
            apply     = ($urandom_range(19) == 0);
            if ($urandom_range(9) == 0) vsync = ~vsync;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/saph_vidgen_ctrl.md
SAPH_VIDGEN_CTRL -- requirements
Module: saph_vidgen_ctrl

Interface
REQ-001 SHALL have parameter div_width, default 6, width of the VGA clock divider field.
REQ-002 SHALL have parameter x_width, default 10, width of the horizontal timing fields.
REQ-003 SHALL have parameter y_width, default 10, width of the vertical timing fields.
REQ-004 SHALL have parameter drain_cycles, default 4, number of en-low cycles before a load; legal range 1..255.
REQ-005 SHALL have parameter timeout_width, default 20, width of the apply-timeout counter.
REQ-006 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock, reset synchronous and active-high.
REQ-007 SHALL have ports reg_we (in, 1, staging write strobe), reg_addr (in, 4, staging index) and reg_wdata (in, 16, write data).
REQ-008 SHALL have port reg_rdata (in-to-out: out, 16, combinational readback of staging[reg_addr], zero-extended; 0 for unmapped addresses).
REQ-009 SHALL have ports run (in, 1, level, requests video output) and apply (in, 1, pulse, requests commit of staging to active).
REQ-010 SHALL have port vsync (in, 1, active-high vsync from the VGA output port).
REQ-011 SHALL have port en (out, 1, generator enable).
REQ-012 SHALL have ports vga_clk_div (out, div_width), h_fp/h_vid/h_bp/h_sync_width (out, x_width each) and v_fp/v_vid/v_bp/v_sync_width (out, y_width each), all driven from active registers.
REQ-013 SHALL have ports busy (out, 1, commit in progress), applied (out, 1, one-cycle pulse on the LOAD cycle) and timeout (out, 1, sticky flag).

Function
REQ-014 SHALL map staging addresses: 0 clk_div, 1 h_fp, 2 h_vid, 3 h_bp, 4 h_sync, 5 v_fp, 6 v_vid, 7 v_bp, 8 v_sync; writes to 9..15 ignored; wdata truncated to the field width.
REQ-015 SHALL keep staging writes possible in every state; staging never changes the outputs except via LOAD.
REQ-016 SHALL implement states OFF, RUN, PEND, DRAIN and LOAD; en=1 only in RUN and PEND.
REQ-017 SHALL transition OFF->RUN when run=1 and no apply is present; OFF->LOAD when apply=1 (apply has priority over run).
REQ-018 SHALL transition RUN->PEND on apply=1, and RUN->DRAIN on run=0 with apply=0; apply has priority.
REQ-019 SHALL transition PEND->DRAIN on the first vsync rising edge (vsync=1 while registered vsync_q=0).
REQ-020 SHALL hold DRAIN for exactly drain_cycles cycles, then go to LOAD if a commit is pending, otherwise to OFF.
REQ-021 SHALL, in LOAD (one cycle), copy all staging fields into active registers, pulse applied, then go to RUN if run=1, otherwise OFF.
REQ-022 SHALL have staging values written in the LOAD cycle itself excluded from the copy and kept in staging.
REQ-023 SHALL assert busy in PEND, DRAIN and LOAD; apply while busy is ignored.
REQ-024 SHALL ignore a run deassertion during PEND until the LOAD decision in REQ-021.

Reset
REQ-025 SHALL, on rst, enter OFF with en=0, busy=0, applied=0, timeout=0, vsync_q=0 and drain/timeout counters=0.
REQ-026 SHALL reset staging and active registers to 640x480: clk_div 0, h_fp 15, h_vid 639, h_bp 47, h_sync 95, v_fp 9, v_vid 479, v_bp 32, v_sync 1.
REQ-027 SHALL abort any in-progress commit on rst, with no partial active update.

Configuration
REQ-028 SHALL, with SAPH_VIDGEN_CTRL_TIMEOUT_EN defined, count PEND cycles and force PEND->DRAIN after 2^timeout_width-1 cycles without a vsync edge, setting timeout (cleared only by rst or by the next apply accepted).
REQ-029 SHALL, without SAPH_VIDGEN_CTRL_TIMEOUT_EN, wait in PEND indefinitely and tie timeout to 0; the port is present in both builds.

Structure
REQ-030 SHALL place the state enum, register-address constants and 640x480 default constants in shared package saph_vidgen_pkg.
REQ-031 SHALL implement staging storage and readback as sub-module saph_vidgen_ctrl_regfile; the FSM, counters and active registers reside in saph_vidgen_ctrl.

Verification
REQ-032 SHALL check: after reset, en=0 and h_vid_width=639; run=1 -> en=1 on the next cycle.
REQ-033 SHALL check: in RUN, write addr 2 = 799, apply -> en stays 1 until the vsync rise, then en=0 for 4 cycles, applied pulses, h_vid_width=799, and en=1 again.
REQ-034 SHALL check: in OFF, write addr 6 = 599 and apply -> LOAD the next cycle, v_vid_width=599, en stays 0.
REQ-035 SHALL check: in RUN, run=0 -> DRAIN for 4 cycles -> OFF, with no applied pulse and active registers unchanged.
REQ-036 SHALL check: a write to addr 1 in the LOAD cycle -> h_fp active keeps the old value while reg_rdata shows the new value; a second apply while busy is ignored.
REQ-037 SHALL check, with the macro and timeout_width=4: apply in RUN with vsync held 0 -> after 15 cycles timeout=1 and the commit completes; rst mid-DRAIN -> OFF with the old active values.
